// File: rtl/axi_pkg.sv
// Shared AXI constants and the bridge FSM state encoding.
`timescale 1ns/1ps
package axi_pkg;

  localparam logic [3:0] AXI_LEN_4  = 4'd3;
  localparam logic [2:0] AXI_SIZE_W = 3'b010;
  localparam logic [1:0] AXI_INCR   = 2'b01;
  localparam logic [3:0] DCACHE_ID  = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_AR    = 3'd1,
    S_R     = 3'd2,
    S_WFILL = 3'd3,
    S_AW    = 3'd4,
    S_W     = 3'd5,
    S_B     = 3'd6
  } state_e;

endpackage

// File: rtl/line_wbuf.sv
// Four-word eviction line buffer: one synchronous write port, one asynchronous read port.
`timescale 1ns/1ps
module line_wbuf (
  input  logic        clk,
  input  logic        wen_i,
  input  logic [1:0]  widx_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  ridx_i,
  output logic [31:0] rdata_o
);

  logic [31:0] mem_q [4];

  always_ff @(posedge clk) begin
    if (wen_i) mem_q[widx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/dcache_axi_bridge.sv
// Turns dcache line refills/evictions into single 4-beat INCR AXI bursts, one at a time.
`timescale 1ns/1ps
module dcache_axi_bridge
  import axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID     = DCACHE_ID,
  parameter int         LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dc_rd_req,
  input  logic        dc_wr_req,
  input  logic [31:0] dc_addr,
  input  logic [31:0] dc_wdata,
  input  logic        dc_wvalid,
  input  logic        dc_wlast,
  output logic        dc_write_begin,
  output logic        dc_wready,
  output logic        dc_awready,
  output logic        dc_bvalid,
  output logic        dc_rvalid,
  output logic        dc_rlast,
  output logic [3:0]  dc_rid,
  output logic [31:0] dc_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam int unused_line_words = LINE_WORDS;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        buf_wen;
  logic [31:0] buf_rdata;
  logic        unused_inputs;

  // Response codes/IDs are not acted on; the low address nibble is forced to zero.
  assign unused_inputs = ^{rresp, bid, bresp, dc_addr[3:0]};

  line_wbuf u_wbuf (
    .clk    (clk),
    .wen_i  (buf_wen),
    .widx_i (cnt_q),
    .wdata_i(dc_wdata),
    .ridx_i (cnt_q),
    .rdata_o(buf_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    buf_wen = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Eviction first so the dirty line leaves before its slot is refilled.
        if (dc_wr_req) begin
          addr_d  = {dc_addr[31:4], 4'h0};
          state_d = S_WFILL;
        end else if (dc_rd_req) begin
          addr_d  = {dc_addr[31:4], 4'h0};
          state_d = S_AR;
        end
      end
      S_AR: if (arready) state_d = S_R;
      S_R:  if (rvalid && rlast) state_d = S_IDLE;
      S_WFILL: begin
        if (dc_wvalid) begin
          buf_wen = 1'b1;
          if (dc_wlast) begin
            cnt_d   = 2'd0;
            state_d = S_AW;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      S_AW: if (awready) state_d = S_W;
      S_W: begin
        if (wready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_B;
        end
      end
      S_B:     if (bvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = AXI_LEN_4;
  assign arsize  = AXI_SIZE_W;
  assign arburst = AXI_INCR;
  assign arvalid = (state_q == S_AR);

  assign rready    = (state_q == S_R);
  assign dc_rvalid = (state_q == S_R) && rvalid;
  assign dc_rlast  = rlast;
  assign dc_rid    = rid;
  assign dc_rdata  = rdata;

  assign dc_write_begin = (state_q == S_WFILL);
  assign dc_wready      = (state_q == S_WFILL);

  assign awid       = AXI_ID;
  assign awaddr     = addr_q;
  assign awlen      = AXI_LEN_4;
  assign awsize     = AXI_SIZE_W;
  assign awburst    = AXI_INCR;
  assign awvalid    = (state_q == S_AW);
  assign dc_awready = (state_q == S_AW) && awready;

  assign wid    = AXI_ID;
  assign wstrb  = 4'hF;
  assign wvalid = (state_q == S_W);
  assign wdata  = (state_q == S_W) ? buf_rdata : 32'd0;
  assign wlast  = (state_q == S_W) && (cnt_q == 2'd3);

  assign bready    = (state_q == S_B);
  assign dc_bvalid = (state_q == S_B) && bvalid;

endmodule
